bp_update_sched: RTL
====================

# bp_update_sched

Commit-side scheduler for the branch predictor's single update port. It accepts up to two retired branch/jump updates per cycle from the ROB commit stage, queues them in order, and issues them one per cycle with a valid/ready handshake. On request it sequences a full predictor-table clear: it drains pending updates, then sweeps every table index. It sits between the ROB's `rob_to_btb_bus` outputs and the BTB/predictor update logic.

## Interface
Parameters:
- `UPD_W`, 72 — width of one packed commit-update record (opaque payload)
- `QDEPTH`, 8 — queue entries; power of two, ≥4
- `BTB_DEPTH_BITS`, 8 — predictor index width; the sweep covers 2^BTB_DEPTH_BITS entries

Ports:
- `clk`  in  1  — single clock
- `rst`  in  1  — reset; one clock; reset is asynchronous and active-high
- `commit0_valid`  in  1  — lane 0 update present (older lane)
- `commit0_data`  in  UPD_W  — lane 0 record
- `commit1_valid`  in  1  — lane 1 update present (younger lane)
- `commit1_data`  in  UPD_W  — lane 1 record
- `commit_ready`  out  1  — the scheduler can accept both lanes this cycle
- `upd_valid`  out  1  — head record offered to the predictor
- `upd_data`  out  UPD_W  — head record
- `upd_ready`  in  1  — predictor consumes the head this cycle
- `flush_req`  in  1  — single-cycle pulse requesting a predictor clear
- `clr_valid`  out  1  — clear write strobe for index `clr_idx`
- `clr_idx`  out  BTB_DEPTH_BITS  — index to clear
- `busy`  out  1  — a flush is in progress (DRAIN or SWEEP)
- `occupancy`  out  clog2(QDEPTH+1)  — current queue count

## Operation
- Storage: a circular buffer of QDEPTH×UPD_W, with head and tail pointers that wrap modulo QDEPTH, and a count register.
- Enqueue happens only when `commit_ready`=1.
  - With both lanes valid, lane 0 is written at the tail and lane 1 at tail+1, and the tail advances by 2.
  - With a single valid lane, that lane is written at the tail and the tail advances by 1.
  - When `commit_ready`=0, lane valids are ignored. Holding them is a ROB obligation.
- `commit_ready` = (state==RUN) && (QDEPTH − count ≥ 2). It is computed from the registered count, so a same-cycle pop does not raise it.
- Dequeue:
  - `upd_valid` = (count≠0) && (state≠SWEEP).
  - `upd_data` = the entry at the head.
  - The head advances on `upd_valid && upd_ready`.
- A push and a pop in the same cycle are legal. The count changes by (pushes − pop).
- State machine:
  - **RUN**: normal operation. `flush_req`=1 → DRAIN.
  - **DRAIN**: no enqueue; the queue continues draining. When count==0 (registered) → SWEEP with `clr_idx`=0.
  - **SWEEP**: `clr_valid`=1 every cycle, with no handshake. `clr_idx` increments by 1 per cycle. The cycle with `clr_idx`=2^BTB_DEPTH_BITS−1 is the last; the next state is RUN and `clr_idx` returns to 0.
- `flush_req` in DRAIN or SWEEP is ignored; it is not queued.
- `busy` = (state≠RUN). `occupancy` = count.

## Timing
- Reset values: state RUN, count 0, head/tail 0, `commit_ready`=1, `upd_valid`=0, `clr_valid`=0, `clr_idx`=0, `busy`=0, `occupancy`=0. Queue contents are don't-care.
- Reset mid-flush aborts the sweep immediately and discards the queue contents.
- Enqueue-to-offer latency: a record pushed at edge N is visible on `upd_data` with `upd_valid`=1 after edge N. This is the cycle after its valid is sampled, provided it reaches the head.
- Peak throughput is 1 update per cycle out and 2 per cycle in, so back-pressure comes through `commit_ready`.
- Order: all records leave in commit order, with lane 0 before lane 1 within a cycle.
- `flush_req` sampled in RUN makes `busy` and `commit_ready` change on the next edge.
  - A flush with an empty queue: DRAIN lasts 1 cycle, then SWEEP lasts 2^BTB_DEPTH_BITS cycles.
  - A flush with count=k and `upd_ready` held high: DRAIN lasts k+1 cycles.
- `upd_valid` is 0 for the whole of SWEEP (count is 0 in SWEEP anyway).
- Count arithmetic never exceeds QDEPTH. With count = QDEPTH−1, `commit_ready`=0 even if only one lane would be valid.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs take their reset values before the next edge; `occupancy`=0 and `commit_ready`=1.
- **Dual push, slow drain:** push A (lane 0) and B (lane 1) in one cycle, with `upd_ready`=0 for 3 cycles and then 1 → `upd_data`=A is held for 4 cycles, then B for 1 cycle; `occupancy` goes 2→1→0.
- **Fill with QDEPTH=8:** push pairs with `upd_ready`=0 → `commit_ready` drops after 4 pairs (count 8). Then raise `upd_ready` → `commit_ready` returns to 1 the cycle after count reaches 6. Pointers wrap and order is preserved across the wrap (check 20 sequential tags).
- **Simultaneous push and pop at count=6:** push 2 and pop 1 → count=7 next cycle and `commit_ready`=0.
- **Flush with 3 queued and `upd_ready`=1:** 3 records drain in order, then 1 cycle with count=0. Then `clr_valid`=1 for 256 consecutive cycles with `clr_idx` 0..255; `busy` deasserts the cycle after idx 255; a second `flush_req` during the sweep has no effect.
- **Lane-1-only push:** `commit1_valid`=1 with `commit0_valid`=0 → exactly one entry is enqueued and `occupancy` increments by 1.

Source files
------------

// File: rtl/bp_update_sched.sv
// Commit-side scheduler for the branch predictor update port: queues up to two
// retired updates per cycle, issues one per cycle, and sequences a full table clear.
module bp_update_sched #(
   parameter int UPD_W          = 72,
   parameter int QDEPTH         = 8,
   parameter int BTB_DEPTH_BITS = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             commit0_valid,
   input  logic [UPD_W-1:0]                 commit0_data,
   input  logic                             commit1_valid,
   input  logic [UPD_W-1:0]                 commit1_data,
   output logic                             commit_ready,
   output logic                             upd_valid,
   output logic [UPD_W-1:0]                 upd_data,
   input  logic                             upd_ready,
   input  logic                             flush_req,
   output logic                             clr_valid,
   output logic [BTB_DEPTH_BITS-1:0]        clr_idx,
   output logic                             busy,
   output logic [$clog2(QDEPTH+1)-1:0]      occupancy
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam int CNT_W = $clog2(QDEPTH+1);
   localparam logic [CNT_W-1:0]          DEPTH_C  = CNT_W'(QDEPTH);
   localparam logic [BTB_DEPTH_BITS-1:0] IDX_LAST = '1;

   typedef enum logic [1:0] {RUN, DRAIN, SWEEP} state_t;

   state_t                    state, state_nxt;
   logic [UPD_W-1:0]          mem [QDEPTH];
   logic [PTR_W-1:0]          head, tail, tail_inc, tail_nxt, head_nxt;
   logic [CNT_W-1:0]          count, count_nxt;
   logic [BTB_DEPTH_BITS-1:0] idx, idx_nxt;
   logic                      push_two, push_one, pop;

   // Ready is derived from the registered count only, so a pop this cycle
   // cannot open room for a push in the same cycle.
   assign commit_ready = (state == RUN) && ((DEPTH_C - count) >= CNT_W'(2));
   assign upd_valid    = (count != '0) && (state != SWEEP);
   assign upd_data     = mem[head];
   assign clr_valid    = (state == SWEEP);
   assign clr_idx      = idx;
   assign busy         = (state != RUN);
   assign occupancy    = count;

   assign pop      = upd_valid && upd_ready;
   assign push_two = commit_ready && commit0_valid && commit1_valid;
   assign push_one = commit_ready && (commit0_valid ^ commit1_valid);
   assign tail_inc = tail + PTR_W'(1);

   always_comb begin
      tail_nxt  = tail;
      head_nxt  = head;
      count_nxt = count;
      if (push_two) begin
         tail_nxt  = tail + PTR_W'(2);
         count_nxt = count + CNT_W'(2);
      end else if (push_one) begin
         tail_nxt  = tail_inc;
         count_nxt = count + CNT_W'(1);
      end
      if (pop) begin
         head_nxt  = head + PTR_W'(1);
         count_nxt = count_nxt - CNT_W'(1);
      end
   end

   // Lane 0 is always older, so it lands at the tail whenever both lanes push.
   always_ff @(posedge clk) begin
      if (push_two) begin
         mem[tail]     <= commit0_data;
         mem[tail_inc] <= commit1_data;
      end else if (push_one) begin
         mem[tail] <= commit0_valid ? commit0_data : commit1_data;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         RUN: begin
            if (flush_req) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (count == '0) begin
               state_nxt = SWEEP;
               idx_nxt   = '0;
            end
         end
         SWEEP: begin
            if (idx == IDX_LAST) begin
               state_nxt = RUN;
               idx_nxt   = '0;
            end else begin
               idx_nxt = idx + BTB_DEPTH_BITS'(1);
            end
         end
         default: begin
            state_nxt = RUN;
            idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         head  <= head_nxt;
         tail  <= tail_nxt;
         count <= count_nxt;
         idx   <= idx_nxt;
      end
   end

endmodule
